// File: rtl/imm_encoder_if.sv
// Handshake and data bundle between the patch/loader path and the immediate encoder.
// The master side supplies the request; the slave side returns status and the encoded field.
interface imm_encoder_if;
  logic        start;
  logic [1:0]  mode;
  logic [31:0] value;
  logic [31:0] pc;
  logic        busy;
  logic        done;
  logic        ok;
  logic [23:0] field;

  modport master (
    output start, mode, value, pc,
    input  busy, done, ok, field
  );

  modport slave (
    input  start, mode, value, pc,
    output busy, done, ok, field
  );
endinterface

// File: rtl/imm_encoder.sv
// Inverse of the immediate extender: turns a constant, offset or branch target into Instr[23:0].
// Rotated imm8 (mode 00) is found by stepping through rotations one per cycle; other modes take one cycle.
module imm_encoder #(
  parameter bit ROT_EN = 1'b1
) (
  input  logic         clk,
  input  logic         reset_n,
  imm_encoder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, SEARCH, DONE} state_t;

  state_t      state;
  state_t      state_next;
  logic [1:0]  mode_q;
  logic [31:0] value_q;
  logic [31:0] pc_q;
  logic [3:0]  rot;
  logic        ok_q;
  logic [23:0] field_q;

  logic        accept;
  logic [4:0]  rot_sh;
  logic [5:0]  rot_back;
  logic [31:0] cand;
  logic        hit;
  logic        last_rot;
  logic [31:0] off;
  logic        calc_ok;
  logic [23:0] calc_field;

  assign accept   = (state == IDLE) && bus.start;
  // A shift of 32 yields zero, so rot 0 leaves the candidate equal to the captured value.
  assign rot_sh   = {rot, 1'b0};
  assign rot_back = 6'd32 - {1'b0, rot_sh};
  assign cand     = (value_q << rot_sh) | (value_q >> rot_back);
  assign hit      = (cand[31:8] == 24'd0);
  assign last_rot = (rot == 4'd15) || !ROT_EN;
  assign off      = value_q - (pc_q + 32'd8);

  always_comb begin
    calc_ok    = 1'b0;
    calc_field = 24'd0;
    case (mode_q)
      2'b01: begin
        calc_ok    = (value_q[31:12] == 20'd0);
        calc_field = {12'd0, value_q[11:0]};
      end
      2'b10: begin
        // Branch offset must be word aligned and fit a signed 26-bit byte offset.
        calc_ok    = (off[1:0] == 2'b00) && (off[31:25] == {7{off[25]}});
        calc_field = off[25:2];
      end
      default: begin
        calc_ok    = 1'b0;
        calc_field = 24'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_next = (bus.mode == 2'b00) ? SEARCH : CALC;
        end
      end
      CALC: state_next = DONE;
      SEARCH: begin
        if (hit || last_rot) begin
          state_next = DONE;
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state != IDLE);
    bus.done = (state == DONE);
  end

  assign bus.ok    = ok_q;
  assign bus.field = field_q;

  // Result registers hold across IDLE and are only cleared when a new request is taken.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q  <= 2'b00;
      value_q <= 32'd0;
      pc_q    <= 32'd0;
      rot     <= 4'd0;
      ok_q    <= 1'b0;
      field_q <= 24'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            mode_q  <= bus.mode;
            value_q <= bus.value;
            pc_q    <= bus.pc;
            rot     <= 4'd0;
            ok_q    <= 1'b0;
            field_q <= 24'd0;
          end
        end
        CALC: begin
          ok_q    <= calc_ok;
          field_q <= calc_ok ? calc_field : 24'd0;
        end
        SEARCH: begin
          if (hit) begin
            ok_q    <= 1'b1;
            field_q <= {12'd0, rot, cand[7:0]};
          end else if (last_rot) begin
            ok_q    <= 1'b0;
            field_q <= 24'd0;
          end else begin
            rot <= rot + 4'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Directed and randomised checks of imm_encoder with rotation search enabled and disabled.
// Each scenario task drives its own vectors and compares against hand-computed or modelled results.
module tb_imm_encoder;

  logic clk = 1'b0;
  logic reset_n;
  int   total = 0;
  int   bad   = 0;

  imm_encoder_if bus1 ();
  imm_encoder_if bus0 ();

  imm_encoder #(.ROT_EN(1'b1)) dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1));
  imm_encoder #(.ROT_EN(1'b0)) dut0 (.clk(clk), .reset_n(reset_n), .bus(bus0));

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  localparam int N0 = 7;
  localparam bit          M0_SEL [N0] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  localparam logic [31:0] M0_VAL [N0] = '{32'h000000AB, 32'h000000AB, 32'hFF000000, 32'h000003FC,
                                          32'h00000101, 32'hFF000000, 32'h00000000};
  localparam int          M0_LAT [N0] = '{1, 1, 5, 16, 16, 1, 1};
  localparam bit          M0_OK  [N0] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
  localparam logic [23:0] M0_FLD [N0] = '{24'h0000AB, 24'h0000AB, 24'h0004FF, 24'h000FFF,
                                          24'h000000, 24'h000000, 24'h000000};

  localparam int NB = 6;
  localparam logic [31:0] MB_VAL [NB] = '{32'h00000200, 32'h00000100, 32'h00000202, 32'h04000108,
                                          32'h02000104, 32'hFE000108};
  localparam bit          MB_OK  [NB] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  localparam logic [23:0] MB_FLD [NB] = '{24'h00003E, 24'hFFFFFE, 24'h000000, 24'h000000,
                                          24'h7FFFFF, 24'h800000};

  function automatic logic [31:0] rotl1(input logic [31:0] x);
    return {x[30:0], x[31]};
  endfunction

  function automatic logic [31:0] rotr1(input logic [31:0] x);
    return {x[0], x[31:1]};
  endfunction

  function automatic void model00(input logic [31:0] v, output logic o, output logic [23:0] f,
                                  output int lat);
    logic [31:0] c;
    c   = v;
    o   = 1'b0;
    f   = 24'd0;
    lat = 16;
    for (int r = 0; r < 16; r++) begin
      if (c < 32'h100) begin
        o   = 1'b1;
        f   = {12'd0, 4'(r), c[7:0]};
        lat = r + 1;
        break;
      end
      c = rotl1(rotl1(c));
    end
  endfunction

  task automatic wait_idle(input bit sel);
    @(negedge clk);
    for (int k = 0; k < 40; k++) begin
      if (!(sel ? bus1.busy : bus0.busy)) break;
      @(negedge clk);
    end
  endtask

  // Issues one request and reports the edge count after acceptance at which done appeared (0 = none).
  task automatic run_op(input bit sel, input logic [1:0] m, input logic [31:0] v, input logic [31:0] p,
                        output int lat, output logic o, output logic [23:0] f);
    wait_idle(sel);
    if (sel) begin
      bus1.start = 1'b1; bus1.mode = m; bus1.value = v; bus1.pc = p;
    end else begin
      bus0.start = 1'b1; bus0.mode = m; bus0.value = v; bus0.pc = p;
    end
    @(posedge clk); #1;
    bus1.start = 1'b0;
    bus0.start = 1'b0;
    lat = 0;
    o   = 1'b0;
    f   = 24'd0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (sel ? bus1.done : bus0.done) begin
        lat = k;
        o   = sel ? bus1.ok : bus0.ok;
        f   = sel ? bus1.field : bus0.field;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({bus1.busy, bus1.done, bus1.ok, bus1.field} !== 27'd0) begin
      bad++;
      $display("[TB] FAIL reset_rot1: busy/done/ok/field=%b/%b/%b/%h want all zero",
               bus1.busy, bus1.done, bus1.ok, bus1.field);
    end
    total++;
    if ({bus0.busy, bus0.done, bus0.ok, bus0.field} !== 27'd0) begin
      bad++;
      $display("[TB] FAIL reset_rot0: busy/done/ok/field=%b/%b/%b/%h want all zero",
               bus0.busy, bus0.done, bus0.ok, bus0.field);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_mode00;
    int lat; logic o; logic [23:0] f;
    for (int i = 0; i < N0; i++) begin
      run_op(M0_SEL[i], 2'b00, M0_VAL[i], 32'd0, lat, o, f);
      total++;
      if (lat !== M0_LAT[i]) begin
        bad++;
        $display("[TB] FAIL mode00_lat[%0d]: got %0d want %0d", i, lat, M0_LAT[i]);
      end
      total++;
      if ({o, f} !== {M0_OK[i], M0_FLD[i]}) begin
        bad++;
        $display("[TB] FAIL mode00_res[%0d]: got ok=%b field=%h want ok=%b field=%h",
                 i, o, f, M0_OK[i], M0_FLD[i]);
      end
    end
  endtask

  task automatic test_mode01;
    int lat; logic o; logic [23:0] f;
    run_op(1'b1, 2'b01, 32'h00000FFF, 32'd0, lat, o, f);
    total++;
    if ({lat == 1, o, f} !== {1'b1, 1'b1, 24'h000FFF}) begin
      bad++;
      $display("[TB] FAIL mode01_fff: got lat=%0d ok=%b field=%h want lat=1 ok=1 field=000fff", lat, o, f);
    end
    run_op(1'b0, 2'b01, 32'h00001000, 32'd0, lat, o, f);
    total++;
    if ({lat == 1, o, f} !== {1'b1, 1'b0, 24'h000000}) begin
      bad++;
      $display("[TB] FAIL mode01_1000: got lat=%0d ok=%b field=%h want lat=1 ok=0 field=000000", lat, o, f);
    end
  endtask

  task automatic test_mode10;
    int lat; logic o; logic [23:0] f;
    for (int i = 0; i < NB; i++) begin
      run_op(1'b1, 2'b10, MB_VAL[i], 32'h00000100, lat, o, f);
      total++;
      if ({lat == 1, o, f} !== {1'b1, MB_OK[i], MB_FLD[i]}) begin
        bad++;
        $display("[TB] FAIL mode10[%0d]: got lat=%0d ok=%b field=%h want lat=1 ok=%b field=%h",
                 i, lat, o, f, MB_OK[i], MB_FLD[i]);
      end
    end
  endtask

  task automatic test_mode11;
    int lat; logic o; logic [23:0] f;
    run_op(1'b1, 2'b11, 32'h00000012, 32'd0, lat, o, f);
    total++;
    if ({lat == 1, o, f} !== {1'b1, 1'b0, 24'h000000}) begin
      bad++;
      $display("[TB] FAIL mode11: got lat=%0d ok=%b field=%h want lat=1 ok=0 field=000000", lat, o, f);
    end
  endtask

  task automatic test_start_ignored;
    int lat;
    wait_idle(1'b1);
    bus1.start = 1'b1; bus1.mode = 2'b00; bus1.value = 32'h000003FC; bus1.pc = 32'd0;
    @(posedge clk); #1;
    bus1.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus1.start = 1'b1; bus1.mode = 2'b01; bus1.value = 32'h00000005;
    @(posedge clk); #1;
    bus1.start = 1'b0;
    lat = 0;
    for (int k = 4; k <= 40; k++) begin
      @(posedge clk); #1;
      if (bus1.done) begin
        lat = k;
        break;
      end
    end
    total++;
    if ({lat == 16, bus1.ok, bus1.field} !== {1'b1, 1'b1, 24'h000FFF}) begin
      bad++;
      $display("[TB] FAIL start_ignored_res: got lat=%0d ok=%b field=%h want lat=16 ok=1 field=000fff",
               lat, bus1.ok, bus1.field);
    end
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({bus1.busy, bus1.done} !== 2'b00) begin
      bad++;
      $display("[TB] FAIL start_ignored_idle: got busy=%b done=%b want 0/0", bus1.busy, bus1.done);
    end
  endtask

  task automatic test_back_to_back;
    wait_idle(1'b1);
    bus1.start = 1'b1; bus1.mode = 2'b01; bus1.value = 32'h00000123; bus1.pc = 32'd0;
    @(posedge clk); #1;
    bus1.start = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({bus1.done, bus1.ok, bus1.field} !== {1'b1, 1'b1, 24'h000123}) begin
      bad++;
      $display("[TB] FAIL b2b_first: got done=%b ok=%b field=%h want 1/1/000123", bus1.done, bus1.ok, bus1.field);
    end
    bus1.start = 1'b1; bus1.value = 32'h00000456;
    @(posedge clk); #1;
    total++;
    if ({bus1.busy, bus1.done, bus1.ok, bus1.field} !== {1'b0, 1'b0, 1'b1, 24'h000123}) begin
      bad++;
      $display("[TB] FAIL b2b_hold: got busy=%b done=%b ok=%b field=%h want 0/0/1/000123",
               bus1.busy, bus1.done, bus1.ok, bus1.field);
    end
    @(posedge clk); #1;
    bus1.start = 1'b0;
    total++;
    if ({bus1.busy, bus1.done, bus1.ok, bus1.field} !== {1'b1, 1'b0, 1'b0, 24'h000000}) begin
      bad++;
      $display("[TB] FAIL b2b_accept: got busy=%b done=%b ok=%b field=%h want 1/0/0/000000",
               bus1.busy, bus1.done, bus1.ok, bus1.field);
    end
    @(posedge clk); #1;
    total++;
    if ({bus1.done, bus1.ok, bus1.field} !== {1'b1, 1'b1, 24'h000456}) begin
      bad++;
      $display("[TB] FAIL b2b_second: got done=%b ok=%b field=%h want 1/1/000456", bus1.done, bus1.ok, bus1.field);
    end
  endtask

  task automatic test_reset_mid;
    bit saw_done;
    wait_idle(1'b1);
    bus1.start = 1'b1; bus1.mode = 2'b00; bus1.value = 32'h000003FC; bus1.pc = 32'd0;
    @(posedge clk); #1;
    bus1.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    total++;
    if (bus1.busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL reset_mid_busy: got busy=%b want 1", bus1.busy);
    end
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    total++;
    if ({bus1.busy, bus1.done, bus1.ok, bus1.field} !== 27'd0) begin
      bad++;
      $display("[TB] FAIL reset_mid_clear: got busy=%b done=%b ok=%b field=%h want all zero",
               bus1.busy, bus1.done, bus1.ok, bus1.field);
    end
    saw_done = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (bus1.done || bus1.busy) saw_done = 1'b1;
    end
    total++;
    if (saw_done !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_mid_nodone: got activity=%b after reset want 0", saw_done);
    end
  endtask

  task automatic test_random;
    int lat; logic o; logic [23:0] f;
    int exp_lat; logic exp_ok; logic [23:0] exp_f;
    logic [1:0] m; logic [31:0] v; logic [31:0] p; logic [31:0] off; logic [31:0] rebuilt;
    for (int it = 0; it < 1000; it++) begin
      m = 2'($urandom_range(0, 3));
      p = $urandom & 32'hFFFFFFFC;
      v = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        case (m)
          2'b00: begin
            v = {24'd0, 8'($urandom)};
            for (int s = 0; s < 2 * $urandom_range(0, 15); s++) v = rotr1(v);
          end
          2'b01: v = $urandom_range(0, 4095);
          2'b10: v = p + 32'd8 + (($urandom & 32'h03FFFFFC) - 32'h02000000);
          default: v = $urandom;
        endcase
      end
      exp_lat = 1;
      exp_ok  = 1'b0;
      exp_f   = 24'd0;
      off     = v - p - 32'd8;
      case (m)
        2'b00: model00(v, exp_ok, exp_f, exp_lat);
        2'b01: if (v < 32'h1000) begin exp_ok = 1'b1; exp_f = v[23:0]; end
        2'b10: if (off[1:0] == 2'b00 && $signed(off) >= -33554432 && $signed(off) <= 33554428) begin
                 exp_ok = 1'b1; exp_f = off[25:2];
               end
        default: ;
      endcase
      run_op(1'b1, m, v, p, lat, o, f);
      total++;
      if ({lat, o, f} !== {exp_lat, exp_ok, exp_f}) begin
        bad++;
        $display("[TB] FAIL rand[%0d] m=%0d v=%h pc=%h: got lat=%0d ok=%b field=%h want lat=%0d ok=%b field=%h",
                 it, m, v, p, lat, o, f, exp_lat, exp_ok, exp_f);
      end
      if (o === 1'b1) begin
        case (m)
          2'b00: begin
            rebuilt = {24'd0, f[7:0]};
            for (int s = 0; s < 2 * int'(f[11:8]); s++) rebuilt = rotr1(rebuilt);
          end
          2'b01: rebuilt = {20'd0, f[11:0]};
          default: rebuilt = {{6{f[23]}}, f, 2'b00} + p + 32'd8;
        endcase
        total++;
        if (rebuilt !== v) begin
          bad++;
          $display("[TB] FAIL roundtrip[%0d] m=%0d field=%h: got %h want %h", it, m, f, rebuilt, v);
        end
      end
    end
  endtask

  initial begin
    bus1.start = 1'b0; bus1.mode = 2'b00; bus1.value = 32'd0; bus1.pc = 32'd0;
    bus0.start = 1'b0; bus0.mode = 2'b00; bus0.value = 32'd0; bus0.pc = 32'd0;
    test_reset;
    test_mode00;
    test_mode01;
    test_mode10;
    test_mode11;
    test_start_ignored;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
